// File: rtl/serial_frame_ctrl_pkg.sv
// serial_frame_ctrl_pkg: shared state encoding and default payload width
package serial_frame_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ONE  = 2'b01,
    DATA = 2'b10,
    PAR  = 2'b11
  } state_t;
  localparam int DEF_DATA_W = 8;
endpackage

// File: rtl/serial_frame_ctrl_frame_out_buf.sv
// frame_out_buf: one-entry valid/ready holding register with overrun flag and frame counter
module frame_out_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_perr,
  input  logic              data_ready,
  input  logic              clr_ovr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              overrun,
  output logic [7:0]        frame_cnt
);
  logic accept, drop;
  assign accept = load & (~data_valid | data_ready);
  assign drop   = load & data_valid & ~data_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      parity_err <= 1'b0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      if (accept) begin
        data_out   <= load_data;
        parity_err <= load_perr;
        frame_cnt  <= frame_cnt + 1'b1;
      end
      data_valid <= accept | (data_valid & ~data_ready);
      overrun    <= drop | (overrun & ~clr_ovr);
    end
  end
endmodule

// File: rtl/serial_frame_ctrl.sv
// serial_frame_ctrl: hunts for a "11" marker, shifts in LSB-first payload plus optional even parity,
// and hands each completed frame to a one-entry output buffer
module serial_frame_ctrl
  import serial_frame_ctrl_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w,
  input  logic              bit_en,
  input  logic              data_ready,
  input  logic              clr_ovr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              overrun,
  output logic              busy,
  output logic [7:0]        frame_cnt
);
  localparam int CW = $clog2(DATA_W);
  state_t            state, state_nx;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg, shreg_nx, load_data;
  logic              last, load, load_perr;
  assign last     = bit_cnt == CW'(DATA_W - 1);
  assign shreg_nx = {w, shreg[DATA_W-1:1]};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else if (bit_en) state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = w ? ONE : IDLE;
      ONE:     state_nx = w ? DATA : IDLE;
      DATA:    state_nx = last ? (PARITY_EN ? PAR : IDLE) : DATA;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    busy      = state != IDLE;
    load      = bit_en & ((state == DATA & last & !PARITY_EN) | state == PAR);
    load_data = (state == PAR) ? shreg : shreg_nx;
    load_perr = PARITY_EN & (state == PAR) & (^shreg ^ w);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (bit_en) begin
      if (state == ONE) bit_cnt <= '0;
      else if (state == DATA) begin
        shreg   <= shreg_nx;
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end
  frame_out_buf #(.DATA_W(DATA_W)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_data  (load_data),
    .load_perr  (load_perr),
    .data_ready (data_ready),
    .clr_ovr    (clr_ovr),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .overrun    (overrun),
    .frame_cnt  (frame_cnt)
  );
endmodule

// File: tb/tb_serial_frame_ctrl.sv
// tb_serial_frame_ctrl: directed checks of framing, parity, buffering and reset
module tb_serial_frame_ctrl;
  logic       clk = 1'b0, rst = 1'b1, w = 1'b0, bit_en = 1'b0, data_ready = 1'b0, clr_ovr = 1'b0;
  logic [7:0] data_out, frame_cnt;
  logic       data_valid, parity_err, overrun, busy;
  int         passed = 0, total = 0;

  serial_frame_ctrl #(.DATA_W(8), .PARITY_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .w(w), .bit_en(bit_en), .data_ready(data_ready), .clr_ovr(clr_ovr),
    .data_out(data_out), .data_valid(data_valid), .parity_err(parity_err), .overrun(overrun),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic send(input logic b, input int gap);
    w = b;
    bit_en = 1'b1;
    @(posedge clk);
    #1;
    bit_en = 1'b0;
    w = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
  endtask

  task automatic frame(input logic [7:0] d, input logic flip, input logic rdy_last, input int gap);
    send(1'b1, gap);
    send(1'b1, gap);
    for (int i = 0; i < 8; i++) send(d[i], gap);
    if (rdy_last) data_ready = 1'b1;
    send(^d ^ flip, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_data_out", data_out, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", frame_cnt, 0);
    rst = 1'b0;
    // good frame; "1,1,1" start makes the third 1 payload bit 0
    data_ready = 1'b1;
    frame(8'hA5, 1'b0, 1'b1, 0);
    chk("good_data", data_out, 8'hA5);
    chk("good_valid", data_valid, 1);
    chk("good_perr", parity_err, 0);
    chk("good_cnt", frame_cnt, 1);
    chk("good_busy", busy, 0);
    @(posedge clk); #1;
    chk("good_consumed", data_valid, 0);
    do_reset();
    frame(8'hA5, 1'b1, 1'b1, 0);
    chk("bad_data", data_out, 8'hA5);
    chk("bad_perr", parity_err, 1);
    chk("bad_cnt", frame_cnt, 1);
    // false start then gapped strobes
    do_reset();
    send(1'b1, 3);
    chk("fs_busy_after_1", busy, 1);
    send(1'b0, 3);
    chk("fs_busy_after_10", busy, 0);
    frame(8'h3C, 1'b0, 1'b1, 3);
    chk("fs_data", data_out, 8'h3C);
    chk("fs_perr", parity_err, 0);
    chk("fs_valid", data_valid, 1);
    // overrun
    do_reset();
    data_ready = 1'b0;
    frame(8'h11, 1'b0, 1'b0, 0);
    frame(8'h22, 1'b0, 1'b0, 0);
    chk("ovr_data", data_out, 8'h11);
    chk("ovr_flag", overrun, 1);
    chk("ovr_cnt", frame_cnt, 1);
    chk("ovr_valid", data_valid, 1);
    clr_ovr = 1'b1;
    @(posedge clk); #1;
    clr_ovr = 1'b0;
    chk("ovr_cleared", overrun, 0);
    data_ready = 1'b1;
    @(posedge clk); #1;
    data_ready = 1'b0;
    chk("ovr_consumed", data_valid, 0);
    chk("ovr_data_kept", data_out, 8'h11);
    // completion coincident with consume
    do_reset();
    frame(8'h11, 1'b0, 1'b0, 0);
    chk("sim_hold_valid", data_valid, 1);
    frame(8'h22, 1'b0, 1'b1, 0);
    data_ready = 1'b0;
    chk("sim_data", data_out, 8'h22);
    chk("sim_valid", data_valid, 1);
    chk("sim_ovr", overrun, 0);
    chk("sim_cnt", frame_cnt, 2);
    // asynchronous reset mid-frame
    send(1'b1, 0);
    send(1'b1, 0);
    for (int i = 0; i < 4; i++) send(1'b0 ^ (i[0]), 0);
    chk("mid_busy_before", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_data", data_out, 0);
    chk("mid_valid", data_valid, 0);
    chk("mid_cnt", frame_cnt, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    frame(8'h5A, 1'b0, 1'b0, 0);
    chk("after_rst_data", data_out, 8'h5A);
    chk("after_rst_cnt", frame_cnt, 1);
    chk("after_rst_perr", parity_err, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
